// File: rtl/cva6_cfg_responder.sv
// Read-only configuration responder: decodes a fixed word map of core parameters
// and returns responses in grant order through a small response FIFO.
module cva6_cfg_responder #(
   parameter int unsigned XLEN         = 32,
   parameter bit          RVA          = 1'b1,
   parameter bit          RVC          = 1'b1,
   parameter bit          FPU_EN       = 1'b0,
   parameter bit          RVH          = 1'b0,
   parameter bit          MMU_EN       = 1'b1,
   parameter bit          DEBUG_EN     = 1'b1,
   parameter int unsigned ICACHE_BYTES = 16384,
   parameter int unsigned ICACHE_WAYS  = 4,
   parameter int unsigned DCACHE_BYTES = 32768,
   parameter int unsigned DCACHE_WAYS  = 8,
   parameter int unsigned NR_COMMIT    = 2,
   parameter int unsigned NR_SB        = 8,
   parameter int unsigned NR_PMP       = 8,
   parameter int unsigned DEPTH        = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        flush_i,
   input  logic        req_i,
   input  logic [7:0]  addr_i,
   output logic        gnt_o,
   output logic        rvalid_o,
   input  logic        rready_i,
   output logic [31:0] rdata_o,
   output logic        err_o
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [32:0]   mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          push, pop;
   logic [31:0]   dec_data;
   logic          dec_err;

   // Handshake: request side transfers when req_i && gnt_o; response side
   // transfers when rvalid_o && rready_i, with the head held stable until then.
   assign rvalid_o = (count != '0);
   assign gnt_o    = req_i && !flush_i &&
                     ((count < CW'(DEPTH)) || ((count == CW'(DEPTH)) && rvalid_o && rready_i));
   assign push     = gnt_o;
   assign pop      = rvalid_o && rready_i && !flush_i;
   assign rdata_o  = rvalid_o ? mem[rd_ptr][32:1] : 32'd0;
   assign err_o    = rvalid_o ? mem[rd_ptr][0]    : 1'b0;

   always_comb begin
      dec_data = 32'd0;
      dec_err  = 1'b0;
      if ((addr_i >= 8'h20) || (addr_i[1:0] != 2'b00)) begin
         dec_err = 1'b1;
      end else begin
         case (addr_i[4:2])
            3'd0: dec_data = 32'hC7A6_0001;
            3'd1: dec_data = 32'(XLEN);
            3'd2: dec_data = {26'd0, DEBUG_EN, MMU_EN, RVH, FPU_EN, RVC, RVA};
            3'd3: dec_data = 32'(ICACHE_BYTES);
            3'd4: dec_data = 32'(ICACHE_WAYS);
            3'd5: dec_data = 32'(DCACHE_BYTES);
            3'd6: dec_data = 32'(DCACHE_WAYS);
            default: dec_data = {8'd0, 8'(NR_PMP), 8'(NR_SB), 8'(NR_COMMIT)};
         endcase
      end
   end

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Storage needs no reset: outputs are masked whenever the FIFO is empty.
   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr] <= {dec_data, dec_err};
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_cva6_cfg_responder.sv
// Bench for cva6_cfg_responder: table-driven reads plus directed corner sequences,
// checked by a negedge scoreboard with an independent occupancy model.
module tb_cva6_cfg_responder;

   localparam int DEPTH = 2;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        flush_i = 1'b0;
   logic        req_i = 1'b0;
   logic [7:0]  addr_i = 8'd0;
   logic        gnt_o;
   logic        rvalid_o;
   logic        rready_i = 1'b0;
   logic [31:0] rdata_o;
   logic        err_o;

   cva6_cfg_responder #(.DEPTH(DEPTH)) dut (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush_i),
      .req_i   (req_i),
      .addr_i  (addr_i),
      .gnt_o   (gnt_o),
      .rvalid_o(rvalid_o),
      .rready_i(rready_i),
      .rdata_o (rdata_o),
      .err_o   (err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [7:0]  addr;
      logic [31:0] data;
      logic        err;
   } vec_t;

   int          total = 0;
   int          bad = 0;
   logic [32:0] exp_q[$];
   logic [31:0] cur_data = '0;
   logic        cur_err = 1'b0;
   logic        last_gnt = 1'b0;
   vec_t        vecs[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge rst_ni) exp_q.delete();

   // Scoreboard: occupancy model decides grants; expected responses queued on grant.
   always @(negedge clk_i) begin
      logic        exp_gnt;
      logic [32:0] head;
      if (!rst_ni) begin
         exp_q.delete();
         last_gnt = 1'b0;
         check("reset_rvalid", {31'd0, rvalid_o}, 32'd0);
         check("reset_rdata", rdata_o, 32'd0);
      end else begin
         exp_gnt = req_i && !flush_i &&
                   ((exp_q.size() < DEPTH) || (exp_q.size() == DEPTH && rready_i));
         check("gnt", {31'd0, gnt_o}, {31'd0, exp_gnt});
         check("rvalid", {31'd0, rvalid_o}, {31'd0, exp_q.size() != 0});
         if (exp_q.size() != 0 && rready_i && !flush_i) begin
            head = exp_q.pop_front();
            check("rdata", rdata_o, head[32:1]);
            check("err", {31'd0, err_o}, {31'd0, head[0]});
         end
         if (flush_i) exp_q.delete();
         if (exp_gnt) exp_q.push_back({cur_data, cur_err});
         last_gnt = gnt_o;
      end
   end

   // Holds the request until granted; rready_i is re-randomised each cycle if asked.
   task automatic send(input logic [7:0] a, input logic [31:0] d, input logic e, input bit rnd);
      addr_i   = a;
      cur_data = d;
      cur_err  = e;
      req_i    = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk_i);
         #1;
         if (last_gnt) begin
            req_i = 1'b0;
            return;
         end
         if (rnd) rready_i = 1'($urandom_range(0, 1));
      end
      total++;
      bad++;
      $display("FAIL grant_timeout: addr %h never granted", a);
      req_i = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   initial begin
      vecs[0]  = '{8'h00, 32'hC7A6_0001, 1'b0};
      vecs[1]  = '{8'h04, 32'd32,        1'b0};
      vecs[2]  = '{8'h08, 32'h0000_0033, 1'b0};
      vecs[3]  = '{8'h0C, 32'd16384,     1'b0};
      vecs[4]  = '{8'h10, 32'd4,         1'b0};
      vecs[5]  = '{8'h14, 32'd32768,     1'b0};
      vecs[6]  = '{8'h18, 32'd8,         1'b0};
      vecs[7]  = '{8'h1C, 32'h0008_0802, 1'b0};
      vecs[8]  = '{8'h22, 32'd0,         1'b1};
      vecs[9]  = '{8'h40, 32'd0,         1'b1};
      vecs[10] = '{8'h01, 32'd0,         1'b1};
      vecs[11] = '{8'h20, 32'd0,         1'b1};
      vecs[12] = '{8'hFF, 32'd0,         1'b1};

      idle(2);
      rst_ni = 1'b1;
      idle(1);

      // Single read right after reset, then back-to-back reads.
      rready_i = 1'b1;
      send(8'h04, 32'd32, 1'b0, 1'b0);
      send(8'h00, 32'hC7A6_0001, 1'b0, 1'b0);
      send(8'h0C, 32'd16384, 1'b0, 1'b0);
      send(8'h1C, 32'h0008_0802, 1'b0, 1'b0);
      idle(2);

      // Whole table, random backpressure.
      for (int r = 0; r < 3; r++)
         for (int i = 0; i < 13; i++)
            send(vecs[i].addr, vecs[i].data, vecs[i].err, 1'b1);
      rready_i = 1'b1;
      idle(4);

      // Backpressure: third request stalls until a pop frees space.
      rready_i = 1'b0;
      send(8'h00, 32'hC7A6_0001, 1'b0, 1'b0);
      send(8'h04, 32'd32, 1'b0, 1'b0);
      addr_i = 8'h08; cur_data = 32'h33; cur_err = 1'b0; req_i = 1'b1;
      idle(3);
      rready_i = 1'b1;
      idle(1);
      check("stall_then_grant", {31'd0, last_gnt}, 32'd1);
      req_i = 1'b0;
      idle(4);

      // Flush a full buffer while a request is pending.
      rready_i = 1'b0;
      send(8'h10, 32'd4, 1'b0, 1'b0);
      send(8'h14, 32'd32768, 1'b0, 1'b0);
      flush_i = 1'b1; req_i = 1'b1; addr_i = 8'h18; cur_data = 32'd8;
      idle(1);
      flush_i = 1'b0; req_i = 1'b0;
      check("flush_empty", {31'd0, rvalid_o}, 32'd0);
      rready_i = 1'b1;
      send(8'h08, 32'h33, 1'b0, 1'b0);
      idle(3);

      // Asynchronous reset with two responses buffered.
      rready_i = 1'b0;
      send(8'h00, 32'hC7A6_0001, 1'b0, 1'b0);
      send(8'h1C, 32'h0008_0802, 1'b0, 1'b0);
      #2 rst_ni = 1'b0;
      #1 check("async_rst_rvalid", {31'd0, rvalid_o}, 32'd0);
      check("async_rst_rdata", rdata_o, 32'd0);
      @(posedge clk_i);
      #2 rst_ni = 1'b1;
      rready_i = 1'b1;
      idle(2);
      send(8'h04, 32'd32, 1'b0, 1'b0);
      idle(3);

      check("drain", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cva6_cfg_responder.md
CVA6_CFG_RESPONDER -- requirements
Module: cva6_cfg_responder

Interface
REQ-001 SHALL have parameter XLEN, default 32, read-back value of word 0x04.
REQ-002 SHALL have parameter RVA/RVC/FPU_EN/RVH/MMU_EN/DEBUG_EN (1 bit each), defaults 1/1/0/0/1/1, ISA feature flags.
REQ-003 SHALL have parameter ICACHE_BYTES, default 16384; ICACHE_WAYS, default 4; DCACHE_BYTES, default 32768; DCACHE_WAYS, default 8.
REQ-004 SHALL have parameter NR_COMMIT, default 2; NR_SB, default 8; NR_PMP, default 8.
REQ-005 SHALL have parameter DEPTH, default 2, response buffer depth (1..8).
REQ-006 Port clk_i, input, 1, single clock, all state rising-edge.
REQ-007 Port rst_ni, input, 1, asynchronous active-low reset.
REQ-008 Port flush_i, input, 1, synchronous discard of buffered responses.
REQ-009 Port req_i, input, 1, read request valid.
REQ-010 Port addr_i, input, 8, byte address.
REQ-011 Port gnt_o, output, 1, request accepted this cycle.
REQ-012 Port rvalid_o, output, 1, response valid.
REQ-013 Port rready_i, input, 1, requester accepts response.
REQ-014 Port rdata_o, output, 32, response data.
REQ-015 Port err_o, output, 1, response error flag, qualified by rvalid_o.

Function
REQ-016 Word map: 0x00 = 32'hC7A6_0001; 0x04 = XLEN; 0x08 = {24'b0, 2'b0, DEBUG_EN, MMU_EN, RVH, FPU_EN, RVC, RVA}; 0x0C = ICACHE_BYTES; 0x10 = ICACHE_WAYS; 0x14 = DCACHE_BYTES; 0x18 = DCACHE_WAYS; 0x1C = {8'b0, NR_PMP[7:0], NR_SB[7:0], NR_COMMIT[7:0]}.
REQ-017 Address >= 0x20 or addr_i[1:0] != 0 SHALL yield response rdata 0, err 1; mapped word yields err 0.
REQ-018 gnt_o = req_i && (count < DEPTH || (count == DEPTH && rvalid_o && rready_i)) && !flush_i, combinational.
REQ-019 Granted request SHALL push {rdata, err} into FIFO at the grant edge; earliest rvalid_o is the next cycle (latency 1).
REQ-020 Response pops when rvalid_o && rready_i; rvalid_o = (count != 0); rdata_o/err_o driven from FIFO head.
REQ-021 Responses SHALL return in grant order; head SHALL remain stable while rvalid_o && !rready_i.
REQ-022 Simultaneous push and pop: count unchanged, pointers both advance.
REQ-023 Read/write pointers SHALL wrap modulo DEPTH; count range 0..DEPTH, never overflows or underflows.
REQ-024 flush_i SHALL set count and pointers to 0 next cycle, deassert gnt_o in the flush cycle, and drop any pop that cycle.
REQ-025 Request held while gnt_o low SHALL be neither buffered nor lost-tracked; requester retries.

Reset
REQ-026 rst_ni low SHALL asynchronously clear count and pointers; rvalid_o=0, rdata_o=0, err_o=0 while count is 0; gnt_o follows REQ-018.
REQ-027 Reset deasserted mid-transaction SHALL discard all buffered responses; first post-reset grant needs no warm-up cycle.

Verification
REQ-028 Reset, req_i=1 addr 0x04, rready_i=1 -> gnt_o=1 same cycle, next cycle rvalid_o=1 rdata_o=32, err_o=0.
REQ-029 Back-to-back reads 0x00, 0x0C, 0x1C with rready_i=1 -> rdata C7A60001, 16384, 0x00080802 in order, one per cycle.
REQ-030 rready_i=0, DEPTH=2, three requests -> two grants, third gnt_o=0 until rready_i=1 pops, then granted same cycle as pop.
REQ-031 Read 0x22 and 0x40 -> rdata_o=0, err_o=1 each.
REQ-032 Buffer full, flush_i=1 -> next cycle rvalid_o=0, count 0; subsequent 0x08 returns 0x33.
REQ-033 rst_ni pulsed low asynchronously while two responses buffered -> rvalid_o drops immediately, no stale response after release.
